// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable up/down LED counter.
//   BOARD_CLK_HZ    : board oscillator frequency
//   DEFAULT_DIVISOR : prescale for a 1 Hz step rate on the board clock
//   MODE_DIR/SAT    : bit positions inside the 2-bit mode input
package prog_counter_pkg;

  localparam int BOARD_CLK_HZ    = 100000000;
  localparam int DEFAULT_DIVISOR = BOARD_CLK_HZ;

  localparam int MODE_DIR = 0;  // 1 = count up, 0 = count down
  localparam int MODE_SAT = 1;  // 1 = saturate, 0 = wrap

endpackage

// File: rtl/prog_updown_counter_tick_gen.sv
// Prescaler producing a single-cycle step enable from the board clock.
//   clock    : board clock, rising edge
//   rst      : synchronous reset, active low
//   restart  : synchronous restart of the prescale period (driven by load)
//   at_end   : combinational, high while the current cycle ends a period
//   tick_out : registered one-cycle pulse on the edge that ends a period
//   blink    : registered ~50% square wave at the period rate
module tick_gen
  import prog_counter_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic clock,
  input  logic rst,
  input  logic restart,
  output logic at_end,
  output logic tick_out,
  output logic blink
);

  localparam int CW_RAW = $clog2(DIVISOR + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;

  assign at_end = (cnt_q == LAST);

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (at_end) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
    // With a one-cycle period the half-period threshold is 0, so force the
    // LED on rather than leaving it permanently dark.
    blink_d = (DIVISOR == 1) ? 1'b1 : (cnt_d < HALF);
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  assign tick_out = tick_q;
  assign blink    = blink_q;

endmodule

// File: rtl/prog_updown_counter.sv
// WIDTH-bit up/down counter with switch preload, wrap/saturate modes,
// count enable and terminal-count pulse, stepped by an internal prescaler.
//   clock    : board clock, rising edge
//   rst      : synchronous reset, active low (loads sw_in)
//   sw_in    : preload value
//   load     : synchronous preload, suppresses the step on that edge
//   en       : qualifies each step
//   mode     : [MODE_DIR] up/down, [MODE_SAT] saturate/wrap
//   cout     : registered count
//   tick_out : one-cycle pulse per prescaler period
//   blink    : square wave at the step rate
//   tc       : one-cycle terminal-count pulse, aligned with the step
module prog_updown_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] cout,
  output logic             tick_out,
  output logic             blink,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             at_end;
  logic             step;
  logic             up, sat;
  logic [WIDTH-1:0] inc, dec;
  logic [WIDTH-1:0] cout_q, cout_d;
  logic             tc_q, tc_d;

  tick_gen #(.DIVISOR(DIVISOR)) u_tick (
    .clock    (clock),
    .rst      (rst),
    .restart  (load),
    .at_end   (at_end),
    .tick_out (tick_out),
    .blink    (blink)
  );

  assign step = at_end & en & ~load;
  assign up   = mode[MODE_DIR];
  assign sat  = mode[MODE_SAT];
  assign inc  = cout_q + ONE;
  assign dec  = cout_q - ONE;

  always_comb begin
    cout_d = cout_q;
    tc_d   = 1'b0;
    if (load) begin
      cout_d = sw_in;
    end else if (step) begin
      if (up) begin
        if (!sat) begin
          cout_d = inc;
          tc_d   = (cout_q == MAX);
        end else if (cout_q != MAX) begin
          cout_d = inc;
          tc_d   = (inc == MAX);
        end
      end else begin
        if (!sat) begin
          cout_d = dec;
          tc_d   = (cout_q == ZERO);
        end else if (cout_q != ZERO) begin
          cout_d = dec;
          tc_d   = (dec == ZERO);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      cout_q <= sw_in;
      tc_q   <= 1'b0;
    end else begin
      cout_q <= cout_d;
      tc_q   <= tc_d;
    end
  end

  assign cout = cout_q;
  assign tc   = tc_q;

endmodule
